// File: rtl/sm_to_twos_stream.sv
// Streaming sign-magnitude to two's-complement converter, 2-stage valid/ready pipeline.
// Optional negative-zero beat counter enabled by defining SM2TC_NZ_COUNT_EN.
module sm_to_twos_stream #(
  parameter int width      = 4,
  parameter int NZ_COUNT_W = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [width-1:0]      In,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [width-1:0]      Out,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  NegZero,
  input  logic                  ClearCount,
  output logic [NZ_COUNT_W-1:0] NegZeroCount
);

  localparam int MW = width - 1;

  // Handshake: a beat transfers on a rising edge where valid && ready are both
  // high; valid never waits on ready, and data/flags hold while valid && !ready.
  logic             s1_valid;
  logic             s1_nz;
  logic [width-1:0] s1_data;
  logic             s2_load;
  logic             s1_load;
  logic             in_fire;
  logic             out_fire;
  logic [MW-1:0]    neg_mag;
  logic [width-1:0] conv;

  assign s2_load  = !OutValid || OutReady;
  assign s1_load  = !s1_valid || s2_load;
  assign InReady  = s1_load && !Reset;
  assign in_fire  = InValid && InReady;
  assign out_fire = OutValid && OutReady;

  // Nonzero magnitudes negate to a nonzero low field, so 100..0 never appears.
  assign neg_mag = (~s1_data[MW-1:0]) + MW'(1);

  always_comb begin
    conv = s1_data;
    if (s1_data[MW]) begin
      if (s1_nz) conv = '0;
      else       conv = {1'b1, neg_mag};
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_nz    <= 1'b0;
      s1_data  <= '0;
    end else if (s1_load) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_data <= In;
        s1_nz   <= In[MW] && (In[MW-1:0] == '0);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      OutValid <= 1'b0;
      Out      <= '0;
      NegZero  <= 1'b0;
    end else if (s2_load) begin
      OutValid <= s1_valid;
      NegZero  <= s1_valid && s1_nz;
      if (s1_valid) Out <= conv;
    end
  end

`ifdef SM2TC_NZ_COUNT_EN
  logic [NZ_COUNT_W-1:0] nz_count;

  // Clear has priority over a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      nz_count <= '0;
    end else if (ClearCount) begin
      nz_count <= '0;
    end else if (out_fire && NegZero && (nz_count != '1)) begin
      nz_count <= nz_count + NZ_COUNT_W'(1);
    end
  end

  assign NegZeroCount = nz_count;
`else
  logic unused_count_inputs;
  assign unused_count_inputs = ClearCount ^ out_fire;
  assign NegZeroCount        = '0;
`endif

endmodule

// File: tb/tb_sm_to_twos_stream.sv
// Bench for sm_to_twos_stream: directed scenarios plus randomized traffic checked
// against an arithmetic reference model and an expected-word queue.
module tb_sm_to_twos_stream;

  localparam int W = 4;
  localparam int C = 2;
  localparam int CNT_MAX = (1 << C) - 1;

  logic         Clock;
  logic         Reset;
  logic [W-1:0] In;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] Out;
  logic         OutValid;
  logic         OutReady;
  logic         NegZero;
  logic         ClearCount;
  logic [C-1:0] NegZeroCount;

  sm_to_twos_stream #(.width(W), .NZ_COUNT_W(C)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .In           (In),
    .InValid      (InValid),
    .InReady      (InReady),
    .Out          (Out),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .NegZero      (NegZero),
    .ClearCount   (ClearCount),
    .NegZeroCount (NegZeroCount)
  );

  // clock / reset
  initial begin
    Clock      = 1'b0;
    Reset      = 1'b1;
    In         = '0;
    InValid    = 1'b0;
    OutReady   = 1'b0;
    ClearCount = 1'b0;
  end
  always #5 Clock = ~Clock;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         exp_nz_q[$];
  int           exp_cnt;
  int           n_checks;
  int           n_fail;

  // per-cycle observations from drive_cycle
  logic         c_in_fire, c_out_fire, c_valid, c_nz, c_have, c_enz, c_eready;
  logic [W-1:0] c_data, c_edata;

  function automatic logic [W-1:0] model_conv(input logic [W-1:0] sm);
    int mag;
    int v;
    mag = int'(sm) & ((1 << (W - 1)) - 1);
    v   = sm[W-1] ? -mag : mag;
    return v[W-1:0];
  endfunction

  function automatic logic model_nz(input logic [W-1:0] sm);
    return sm[W-1] && ((int'(sm) & ((1 << (W - 1)) - 1)) == 0);
  endfunction

  // Called just after a falling edge: drive, observe, advance model, wait one cycle.
  task automatic drive_cycle(input logic iv, input logic [W-1:0] din,
                             input logic ordy, input logic clr);
    InValid    = iv;
    In         = din;
    OutReady   = ordy;
    ClearCount = clr;
    #1;
    c_eready   = (exp_q.size() < 2) || ordy;
    c_in_fire  = InValid && InReady;
    c_out_fire = OutValid && OutReady;
    c_valid    = OutValid;
    c_data     = Out;
    c_nz       = NegZero;
    c_have     = 1'b0;
    c_edata    = '0;
    c_enz      = 1'b0;
    if (c_out_fire && exp_q.size() > 0) begin
      c_have  = 1'b1;
      c_edata = exp_q.pop_front();
      c_enz   = exp_nz_q.pop_front();
    end
    if (c_in_fire) begin
      exp_q.push_back(model_conv(din));
      exp_nz_q.push_back(model_nz(din));
    end
`ifdef SM2TC_NZ_COUNT_EN
    if (clr) exp_cnt = 0;
    else if (c_out_fire && c_have && c_enz && exp_cnt < CNT_MAX) exp_cnt++;
`endif
    @(negedge Clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clock);
    #1;
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid got=%b want=0", OutValid); end
    n_checks++; if (Out !== '0) begin n_fail++; $display("FAIL reset_out got=%b want=0000", Out); end
    n_checks++; if (NegZero !== 1'b0) begin n_fail++; $display("FAIL reset_negzero got=%b want=0", NegZero); end
    n_checks++; if (NegZeroCount !== '0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", NegZeroCount); end
    n_checks++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL reset_inready got=%b want=0", InReady); end
    @(negedge Clock);
    Reset = 1'b0;
    exp_cnt = 0;
    @(negedge Clock);
    #1;
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL post_reset_inready got=%b want=1", InReady); end
    @(negedge Clock);
  endtask

  task automatic test_basic();
    logic [W-1:0] words[4];
    logic [W-1:0] want[4];
    int idx, n_del, first_acc, first_del;
    words = '{4'b0101, 4'b1101, 4'b1111, 4'b0000};
    want  = '{4'b0101, 4'b1011, 4'b1001, 4'b0000};
    idx = 0; n_del = 0; first_acc = -1; first_del = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive_cycle(idx < 4, (idx < 4) ? words[idx] : 4'b0000, 1'b1, 1'b0);
      if (c_in_fire) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      if (c_out_fire) begin
        if (first_del < 0) first_del = cyc;
        if (n_del < 4) begin
          n_checks++; if (c_data !== want[n_del]) begin n_fail++; $display("FAIL basic_out[%0d] got=%b want=%b", n_del, c_data, want[n_del]); end
        end
        n_checks++; if (c_nz !== 1'b0) begin n_fail++; $display("FAIL basic_negzero[%0d] got=%b want=0", n_del, c_nz); end
        n_del++;
      end
    end
    n_checks++; if (n_del != 4) begin n_fail++; $display("FAIL basic_count got=%0d want=4", n_del); end
    n_checks++; if (first_del != first_acc + 2) begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", first_del - first_acc, 2); end
  endtask

  task automatic test_neg_zero();
    int n_del;
    drive_cycle(1'b0, 4'b0000, 1'b1, 1'b1);
    n_checks++; if (NegZeroCount !== exp_cnt[C-1:0]) begin n_fail++; $display("FAIL nz_cleared got=%0d want=%0d", NegZeroCount, exp_cnt); end
    n_del = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive_cycle(cyc == 0, 4'b1000, 1'b1, 1'b0);
      if (c_out_fire) begin
        n_checks++; if (c_data !== 4'b0000) begin n_fail++; $display("FAIL nz_out got=%b want=0000", c_data); end
        n_checks++; if (c_nz !== 1'b1) begin n_fail++; $display("FAIL nz_flag got=%b want=1", c_nz); end
        n_del++;
      end
    end
    n_checks++; if (n_del != 1) begin n_fail++; $display("FAIL nz_delivered got=%0d want=1", n_del); end
`ifdef SM2TC_NZ_COUNT_EN
    n_checks++; if (NegZeroCount !== 2'd1) begin n_fail++; $display("FAIL nz_count got=%0d want=1", NegZeroCount); end
`else
    n_checks++; if (NegZeroCount !== 2'd0) begin n_fail++; $display("FAIL nz_count_disabled got=%0d want=0", NegZeroCount); end
`endif
  endtask

  task automatic test_backpressure();
    logic [W-1:0] words[3];
    logic [W-1:0] want[3];
    int idx, n_del;
    words = '{4'b1001, 4'b1010, 4'b1011};
    want  = '{4'b1111, 4'b1110, 4'b1101};
    idx = 0; n_del = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive_cycle(idx < 3, (idx < 3) ? words[idx] : 4'b0000, 1'b0, 1'b0);
      if (c_in_fire) idx++;
      if (cyc >= 2) begin
        n_checks++; if (c_in_fire !== 1'b0) begin n_fail++; $display("FAIL bp_inready cyc=%0d got=1 want=0", cyc); end
        n_checks++; if (c_valid !== 1'b1 || c_data !== 4'b1111) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%b want=1/1111", cyc, c_valid, c_data); end
      end
    end
    n_checks++; if (idx != 2) begin n_fail++; $display("FAIL bp_accepts got=%0d want=2", idx); end
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive_cycle(idx < 3, (idx < 3) ? words[idx] : 4'b0000, 1'b1, 1'b0);
      if (c_in_fire) idx++;
      if (c_out_fire) begin
        if (n_del < 3) begin
          n_checks++; if (c_data !== want[n_del]) begin n_fail++; $display("FAIL bp_out[%0d] got=%b want=%b", n_del, c_data, want[n_del]); end
        end
        n_del++;
      end
    end
    n_checks++; if (n_del != 3) begin n_fail++; $display("FAIL bp_delivered got=%0d want=3", n_del); end
  endtask

  task automatic test_saturation();
    int n_sent;
    drive_cycle(1'b0, 4'b0000, 1'b1, 1'b1);
    n_sent = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive_cycle(n_sent < 5, 4'b1000, 1'b1, 1'b0);
      if (c_in_fire) n_sent++;
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sat_drain got=%0d want=0 pending", exp_q.size()); end
`ifdef SM2TC_NZ_COUNT_EN
    n_checks++; if (NegZeroCount !== 2'd3) begin n_fail++; $display("FAIL sat_count got=%0d want=3", NegZeroCount); end
`else
    n_checks++; if (NegZeroCount !== 2'd0) begin n_fail++; $display("FAIL sat_count_disabled got=%0d want=0", NegZeroCount); end
`endif
    drive_cycle(1'b1, 4'b1000, 1'b1, 1'b0);
    drive_cycle(1'b0, 4'b0000, 1'b1, 1'b0);
    drive_cycle(1'b0, 4'b0000, 1'b1, 1'b1);
    n_checks++; if (c_out_fire !== 1'b1 || c_nz !== 1'b1) begin n_fail++; $display("FAIL sat_sixth got=%b/%b want=1/1", c_out_fire, c_nz); end
    n_checks++; if (NegZeroCount !== 2'd0) begin n_fail++; $display("FAIL sat_clear_wins got=%0d want=0", NegZeroCount); end
  endtask

  task automatic test_random();
    logic [W-1:0] din;
    for (int cyc = 0; cyc < 400; cyc++) begin
      din = W'($urandom_range(0, (1 << W) - 1));
      drive_cycle($urandom_range(0, 3) != 0, din, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0);
      n_checks++; if (c_in_fire !== c_eready && InValid) begin n_fail++; $display("FAIL rnd_inready cyc=%0d got=%b want=%b", cyc, c_in_fire, c_eready); end
      if (c_out_fire) begin
        n_checks++; if (c_have !== 1'b1) begin n_fail++; $display("FAIL rnd_unexpected cyc=%0d got=%b want=none", cyc, c_data); end
        n_checks++; if (c_data !== c_edata || c_nz !== c_enz) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%b/%b want=%b/%b", cyc, c_data, c_nz, c_edata, c_enz); end
      end
      n_checks++; if (NegZeroCount !== exp_cnt[C-1:0]) begin n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, NegZeroCount, exp_cnt); end
    end
    for (int cyc = 0; cyc < 10 && exp_q.size() > 0; cyc++) begin
      drive_cycle(1'b0, 4'b0000, 1'b1, 1'b0);
      if (c_out_fire) begin
        n_checks++; if (c_data !== c_edata || c_nz !== c_enz) begin n_fail++; $display("FAIL rnd_drain got=%b/%b want=%b/%b", c_data, c_nz, c_edata, c_enz); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_timeout got=%0d want=0 pending", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    int n_del;
    drive_cycle(1'b1, 4'b0110, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'b1100, 1'b0, 1'b0);
    #2;
    n_checks++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got=%b want=1", OutValid); end
    Reset = 1'b1;
    #1;
    n_checks++; if (OutValid !== 1'b0 || Out !== '0) begin n_fail++; $display("FAIL mid_reset got=%b/%b want=0/0000", OutValid, Out); end
    n_checks++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL mid_reset_inready got=%b want=0", InReady); end
    exp_q.delete();
    exp_nz_q.delete();
    exp_cnt = 0;
    @(negedge Clock);
    Reset = 1'b0;
    n_del = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive_cycle(1'b0, 4'b0000, 1'b1, 1'b0);
      if (c_out_fire) n_del++;
    end
    n_checks++; if (n_del != 0) begin n_fail++; $display("FAIL mid_stale got=%0d want=0", n_del); end
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive_cycle(cyc == 0, 4'b1011, 1'b1, 1'b0);
      if (c_out_fire) begin
        n_checks++; if (c_data !== 4'b1101) begin n_fail++; $display("FAIL mid_next got=%b want=1101", c_data); end
        n_del++;
      end
    end
    n_checks++; if (n_del != 1) begin n_fail++; $display("FAIL mid_next_count got=%0d want=1", n_del); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    test_reset();
    test_basic();
    test_neg_zero();
    test_backpressure();
    test_saturation();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
